ipsxe_floating_point_exp_inv_square_v1_0: RTL
=============================================

// Module: ipsxe_floating_point_exp_inv_square_v1_0
// PURPOSE
//  Exponent path of the x^-2 (reciprocal-square) unit: the inverse direction of the invsqrt exponent stage.
//  - Takes a biased IEEE-754 exponent plus the normalization adjust from the mantissa path.
//  - Returns the biased exponent of 1/x^2 with special-case and overflow/underflow classification.
//  - 2-stage elastic pipeline, valid/ready on both sides; sits beside the mantissa datapath in the flt core.
// PARAMETERS
//  EXPONENT_SIZE  11  exponent width; bias B = 2^(EXPONENT_SIZE-1)-1
// PORTS
//  i_clk            in   1       clock; all logic on rising edge
//  i_rst_n          in   1       asynchronous active-low reset
//  i_valid          in   1       input beat valid
//  o_ready          out  1       input beat accepted when i_valid & o_ready
//  i_exp            in   EXP     biased input exponent e
//  i_mant_zero      in   1       input fraction field == 0
//  i_norm_adj       in   2       0: m==1 exactly; 1: 1/m^2 in [1/2,1); 2: 1/m^2 in (1/4,1/2); 3 illegal (treated as 2)
//  o_valid          out  1       result valid
//  i_ready          in   1       downstream accepts when o_valid & i_ready
//  o_exp            out  EXP     biased result exponent
//  o_class          out  2       00 normal, 01 zero, 10 inf, 11 NaN
//  o_ovf            out  1       finite input overflowed to inf
//  o_unf            out  1       finite input underflowed to zero
// BEHAVIOUR
//  - Reset: o_valid=0, o_exp=0, o_class=00, o_ovf=0, o_unf=0; both stages empty; o_ready=1 after reset.
//  - Math: r = 3*B - 2*e - adj, computed signed in EXPONENT_SIZE+3 bits with no truncation before classification.
//  - Normal input (0<e<all-ones):
//    - r >= 2^EXP-1: o_exp=all-ones, class=10, o_ovf=1.
//    - r <= 0: o_exp=0, class=01, o_unf=1. Subnormals are not produced.
//    - else: o_exp=r[EXP-1:0], class=00.
//  - e==0 (zero/denorm flushed): o_exp=all-ones, class=10, o_ovf=0.
//  - e==all-ones & i_mant_zero: o_exp=0, class=01. e==all-ones & !i_mant_zero: o_exp=all-ones, class=11.
//  - Stage 1 registers:
//    - 2*e+adj.
//    - special-case decode.
//  - Stage 2 registers:
//    - subtraction.
//    - range check.
//    - outputs.
//  - Stage 2 drives o_* directly. Latency is 2 cycles from acceptance to o_valid when never stalled.
//  - Each stage holds a valid bit and advances when the next stage is empty or advancing.
//  - o_ready = !s1_valid | !s2_valid | i_ready. o_ready is combinational from i_ready; there is no skid buffer.
//  - Stall: while o_valid & !i_ready, o_exp, o_class, o_ovf and o_unf hold stable. There is no bubble insertion and no data loss.
//  - Throughput is 1 beat/cycle with i_ready held high. Accept and emit in the same cycle is legal.
//  - Inputs are sampled only on an accepted beat.
//  - Reset mid-operation: in-flight beats are discarded, o_valid drops asynchronously, and no partial beat is emitted.
// CONFIGURATION
//  - Macro: IPSXE_FLOATING_POINT_EXP_STATUS_CNT_EN.
//  - Defined:
//    - Adds ports o_ovf_cnt (out, 16) and o_unf_cnt (out, 16) and input i_cnt_clr (in, 1, synchronous).
//    - o_ovf_cnt / o_unf_cnt count emitted beats (o_valid & i_ready) with o_ovf / o_unf = 1.
//    - Counters saturate at 16'hFFFF and reset to 0.
//    - i_cnt_clr zeroes both counters. If clear and an increment coincide, the clear wins.
//  - Undefined: the extra ports and counters do not exist; datapath timing is identical.
// TESTING (EXPONENT_SIZE=8, B=127)
//  - Normal results, i_ready=1:
//    - e=127, adj=0 -> o_exp=127, class=00, 2 cycles after accept.
//    - e=128, adj=0 -> 125.
//    - e=127, adj=2 -> 125.
//  - Range edges:
//    - e=190, adj=0 -> 1 normal.
//    - e=191, adj=0 -> 0, class=01, o_unf=1.
//    - e=64, adj=0 -> 253.
//    - e=63, adj=0 -> 255, class=10, o_ovf=1.
//  - Specials:
//    - e=0 -> 255/10, o_ovf=0.
//    - e=255, mant_zero=1 -> 0/01.
//    - e=255, mant_zero=0 -> 255/11.
//  - Backpressure:
//    - Stream 8 beats with i_ready=0 for cycles 3-6 -> o_ready low once both stages are full.
//    - All 8 results arrive in order, unchanged during the stall, with none dropped or duplicated.
//  - Reset: assert i_rst_n=0 with 2 beats in flight -> o_valid=0 immediately. After release, the first result is from a new beat.
//  - With IPSXE_FLOATING_POINT_EXP_STATUS_CNT_EN:
//    - 3 overflow beats -> o_ovf_cnt=3.
//    - Pulse i_cnt_clr coincident with a 4th overflow beat -> o_ovf_cnt=0.
//    - Force 65540 underflows -> o_unf_cnt=16'hFFFF.

Source files
------------

// File: rtl/ipsxe_floating_point_exp_inv_square_v1_0.sv
// Exponent path of the 1/x^2 unit: biased exponent plus mantissa normalization adjust -> biased result exponent with class and ovf/unf.
// Latency 2 cycles (stage 1: 2e+adj and special decode; stage 2: subtract, range check, registered outputs).
// Backpressure: elastic valid/ready, o_ready = !s1 | !s2 | i_ready (combinational, no skid); outputs hold while stalled.
// Optional build macro IPSXE_FLOATING_POINT_EXP_STATUS_CNT_EN adds saturating overflow/underflow beat counters.
module ipsxe_floating_point_exp_inv_square_v1_0 #(
  parameter int EXPONENT_SIZE = 11
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [EXPONENT_SIZE-1:0] i_exp,
  input  logic                     i_mant_zero,
  input  logic [1:0]               i_norm_adj,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [EXPONENT_SIZE-1:0] o_exp,
  output logic [1:0]               o_class,
  output logic                     o_ovf,
`ifdef IPSXE_FLOATING_POINT_EXP_STATUS_CNT_EN
  output logic                     o_unf,
  input  logic                     i_cnt_clr,
  output logic [15:0]              o_ovf_cnt,
  output logic [15:0]              o_unf_cnt
`else
  output logic                     o_unf
`endif
);

  // Signed working width: wide enough for 3*B and for 2*e+adj with no wrap.
  localparam int W    = EXPONENT_SIZE + 3;
  localparam int BIAS = (2 ** (EXPONENT_SIZE - 1)) - 1;
  localparam logic signed [W-1:0] BIAS3 = W'(3 * BIAS);
  localparam logic signed [W-1:0] R_MAX = W'((2 ** EXPONENT_SIZE) - 1);

  // Result classes.
  localparam logic [1:0] CLS_NORM = 2'b00;
  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  // Special-case codes carried from stage 1 to stage 2.
  localparam logic [1:0] SP_NONE = 2'b00;  // finite normal input, use arithmetic
  localparam logic [1:0] SP_ZIN  = 2'b01;  // zero/denormal input -> infinity
  localparam logic [1:0] SP_IIN  = 2'b10;  // infinite input -> zero
  localparam logic [1:0] SP_NAN  = 2'b11;  // NaN input -> NaN

  // Handshake: a stage can take a new beat when empty or when it is being drained.
  logic s1_vld_q, s2_vld_q;
  logic s1_rdy, s2_rdy, s1_load, s2_load;

  assign s2_rdy  = !s2_vld_q || i_ready;
  assign s1_rdy  = !s1_vld_q || s2_rdy;
  assign o_ready = s1_rdy;
  assign s1_load = i_valid && s1_rdy;
  assign s2_load = s1_vld_q && s2_rdy;
  assign o_valid = s2_vld_q;

  // ---------------- Stage 1 ----------------
  logic [1:0]   adj_eff;
  logic [W-1:0] s1_sum_d, s1_sum_q;
  logic [1:0]   s1_spec_d, s1_spec_q;

  // Form 2*e+adj and decode the special input encodings.
  always_comb begin
    adj_eff   = (i_norm_adj == 2'd3) ? 2'd2 : i_norm_adj;
    s1_sum_d  = {2'b00, i_exp, 1'b0} + W'(adj_eff);
    s1_spec_d = SP_NONE;
    if (i_exp == '0) begin
      s1_spec_d = SP_ZIN;
    end else if (&i_exp) begin
      s1_spec_d = i_mant_zero ? SP_IIN : SP_NAN;
    end
  end

  // Stage 1 valid bit follows the input whenever the stage is allowed to move.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld_q <= 1'b0;
    end else if (s1_rdy) begin
      s1_vld_q <= i_valid;
    end
  end

  // Stage 1 payload is captured only on an accepted beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_sum_q  <= '0;
      s1_spec_q <= SP_NONE;
    end else if (s1_load) begin
      s1_sum_q  <= s1_sum_d;
      s1_spec_q <= s1_spec_d;
    end
  end

  // ---------------- Stage 2 ----------------
  logic signed [W-1:0]     r_s;
  logic [EXPONENT_SIZE-1:0] exp_d, exp_q;
  logic [1:0]               cls_d, cls_q;
  logic                     ovf_d, ovf_q;
  logic                     unf_d, unf_q;

  // Subtract from 3B and classify; special inputs override the arithmetic result.
  always_comb begin
    r_s   = BIAS3 - $signed(s1_sum_q);
    exp_d = '0;
    cls_d = CLS_NORM;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    case (s1_spec_q)
      SP_ZIN: begin
        exp_d = '1;
        cls_d = CLS_INF;
      end
      SP_IIN: begin
        exp_d = '0;
        cls_d = CLS_ZERO;
      end
      SP_NAN: begin
        exp_d = '1;
        cls_d = CLS_NAN;
      end
      default: begin
        if (r_s >= R_MAX) begin
          exp_d = '1;
          cls_d = CLS_INF;
          ovf_d = 1'b1;
        end else if (r_s[W-1] || (r_s == '0)) begin
          // No subnormal outputs: anything at or below zero flushes.
          exp_d = '0;
          cls_d = CLS_ZERO;
          unf_d = 1'b1;
        end else begin
          exp_d = r_s[EXPONENT_SIZE-1:0];
          cls_d = CLS_NORM;
        end
      end
    endcase
  end

  // Stage 2 valid bit: refilled from stage 1 (possibly with a bubble) when it may move.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_vld_q <= 1'b0;
    end else if (s2_rdy) begin
      s2_vld_q <= s1_vld_q;
    end
  end

  // Stage 2 payload only changes when a real beat moves in, so outputs hold during a stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_q <= '0;
      cls_q <= CLS_NORM;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (s2_load) begin
      exp_q <= exp_d;
      cls_q <= cls_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign o_exp   = exp_q;
  assign o_class = cls_q;
  assign o_ovf   = ovf_q;
  assign o_unf   = unf_q;

`ifdef IPSXE_FLOATING_POINT_EXP_STATUS_CNT_EN
  // ---------------- Status counters ----------------
  logic        out_fire;
  logic [15:0] ovf_cnt_d, ovf_cnt_q;
  logic [15:0] unf_cnt_d, unf_cnt_q;

  assign out_fire = s2_vld_q && i_ready;

  // Saturating counts of emitted overflow/underflow beats; clear has priority.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    if (i_cnt_clr) begin
      ovf_cnt_d = '0;
      unf_cnt_d = '0;
    end else begin
      if (out_fire && ovf_q && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
      if (out_fire && unf_q && (unf_cnt_q != 16'hFFFF)) unf_cnt_d = unf_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  assign o_ovf_cnt = ovf_cnt_q;
  assign o_unf_cnt = unf_cnt_q;
`endif

endmodule
